// File: rtl/stream_patch_mc.sv
// stream_patch_mc
//   Multi-channel raster patch extractor. For every accepted pixel it produces the
//   PATCH_HEIGHT x PATCH_WIDTH neighbourhood around the pixel that entered L enabled
//   cycles earlier. Image borders are handled by a runtime-selectable padding mode.
//
// Handshake: there is no back-pressure. 'enable' qualifies every input and every
//   state update. A cycle with enable=0 is a full stall: nothing moves, and the
//   registered outputs hold except out_valid, which reads 0 after that edge.
//   out_valid=1 marks a patch and centre coordinate that are valid in that cycle.
//
// Ports
//   clock, rst      : clock and synchronous active-high reset
//   enable          : advance the pipeline by one pixel
//   pad_mode        : 0 zero, 1 replicate, 2 mirror, 3 behaves as zero
//   in_pixel        : channel c at [c*BIT_WIDTH +: BIT_WIDTH]
//   in_vcnt/in_hcnt : frame-timed coordinate of in_pixel
//   out_patch       : element e=(v*PATCH_WIDTH+h)*CHANNELS+c at [e*BIT_WIDTH +: BIT_WIDTH]
//   out_vcnt/out_hcnt : centre coordinate of out_patch
//   out_valid       : out_patch and coordinates are valid
module stream_patch_mc #(
  parameter int BIT_WIDTH    = 8,
  parameter int CHANNELS     = 3,
  parameter int IMAGE_HEIGHT = 480,
  parameter int IMAGE_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 525,
  parameter int FRAME_WIDTH  = 800,
  parameter int PATCH_HEIGHT = 3,
  parameter int PATCH_WIDTH  = 3,
  parameter int CENTER_V     = PATCH_HEIGHT / 2,
  parameter int CENTER_H     = PATCH_WIDTH / 2,
  localparam int V_BITW      = $clog2(FRAME_HEIGHT),
  localparam int H_BITW      = $clog2(FRAME_WIDTH),
  localparam int PIX_W       = CHANNELS * BIT_WIDTH,
  localparam int PATCH_BITW  = PIX_W * PATCH_HEIGHT * PATCH_WIDTH
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            pad_mode,
  input  logic [PIX_W-1:0]      in_pixel,
  input  logic [V_BITW-1:0]     in_vcnt,
  input  logic [H_BITW-1:0]     in_hcnt,
  output logic [0:PATCH_BITW-1] out_patch,
  output logic [V_BITW-1:0]     out_vcnt,
  output logic [H_BITW-1:0]     out_hcnt,
  output logic                  out_valid
);

  localparam int LB_DEPTH = FRAME_WIDTH - PATCH_WIDTH;
  localparam int PTR_W    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  // Enabled cycles from a pixel's acceptance until it sits in the centre register.
  localparam int LAT      = (PATCH_HEIGHT - 1 - CENTER_V) * FRAME_WIDTH
                          + (PATCH_WIDTH - 1 - CENTER_H) + 1;

  // win[PATCH_HEIGHT-1][PATCH_WIDTH-1] holds the newest pixel; row v sees the
  // raster (PATCH_HEIGHT-1-v) frame lines earlier.
  logic [PIX_W-1:0]  win    [PATCH_HEIGHT][PATCH_WIDTH];
  logic [PIX_W-1:0]  lb_mem [PATCH_HEIGHT-1][LB_DEPTH];
  logic [PTR_W-1:0]  lb_ptr;
  logic [V_BITW-1:0] v_pipe [LAT];
  logic [H_BITW-1:0] h_pipe [LAT];
  logic              a_pipe [LAT];
  logic              armed;
  logic              armed_next;
  logic [1:0]        act_mode;
  logic [1:0]        eff_mode;
  logic [V_BITW-1:0] ctr_v;
  logic [H_BITW-1:0] ctr_h;
  logic              ctr_armed;
  logic              patch_valid;
  logic [0:PATCH_BITW-1] patch;

  assign armed_next  = armed | (in_vcnt == '0 && in_hcnt == '0);
  assign ctr_v       = v_pipe[LAT-1];
  assign ctr_h       = h_pipe[LAT-1];
  assign ctr_armed   = a_pipe[LAT-1];
  // The frame's first patch already uses the mode being latched for that frame.
  assign eff_mode    = (ctr_v == '0 && ctr_h == '0) ? pad_mode : act_mode;
  assign patch_valid = ctr_armed && (int'(ctr_v) < IMAGE_HEIGHT)
                                 && (int'(ctr_h) < IMAGE_WIDTH);

  // Maps an image index to the source index under the given padding mode.
  // Returns -1 when the element must be zero.
  function automatic int remap(input int p, input int n, input logic [1:0] mode);
    int r;
    if (p >= 0 && p < n)     r = p;
    else if (mode == 2'd1)   r = (p < 0) ? 0 : n - 1;
    else if (mode == 2'd2)   r = (p < 0) ? -p : 2 * n - 2 - p;
    else                     r = -1;
    return r;
  endfunction

  // Padding is a pure index remap: each output element selects one window register.
  always_comb begin
    patch = '0;
    for (int v = 0; v < PATCH_HEIGHT; v++) begin
      for (int h = 0; h < PATCH_WIDTH; h++) begin
        int src_r;
        int src_c;
        int win_r;
        int win_c;
        logic [PIX_W-1:0] sel;
        src_r = remap(int'(ctr_v) + v - CENTER_V, IMAGE_HEIGHT, eff_mode);
        src_c = remap(int'(ctr_h) + h - CENTER_H, IMAGE_WIDTH, eff_mode);
        win_r = src_r - int'(ctr_v) + CENTER_V;
        win_c = src_c - int'(ctr_h) + CENTER_H;
        sel   = '0;
        if (src_r >= 0 && src_c >= 0) begin
          for (int rr = 0; rr < PATCH_HEIGHT; rr++) begin
            for (int cc = 0; cc < PATCH_WIDTH; cc++) begin
              if (rr == win_r && cc == win_c) sel = win[rr][cc];
            end
          end
        end
        for (int c = 0; c < CHANNELS; c++) begin
          patch[((v * PATCH_WIDTH + h) * CHANNELS + c) * BIT_WIDTH +: BIT_WIDTH] =
            sel[c * BIT_WIDTH +: BIT_WIDTH];
        end
      end
    end
  end

  // Pixel storage and coordinate delay line; contents are not reset.
  always_ff @(posedge clock) begin
    if (enable) begin
      for (int v = 0; v < PATCH_HEIGHT; v++) begin
        for (int h = 0; h < PATCH_WIDTH - 1; h++) begin
          win[v][h] <= win[v][h+1];
        end
      end
      // Each line buffer closes a row loop: PATCH_WIDTH-1 shifts + LB_DEPTH + 1 = FRAME_WIDTH.
      for (int v = 0; v < PATCH_HEIGHT - 1; v++) begin
        win[v][PATCH_WIDTH-1] <= lb_mem[v][lb_ptr];
        lb_mem[v][lb_ptr]     <= win[v+1][0];
      end
      win[PATCH_HEIGHT-1][PATCH_WIDTH-1] <= in_pixel;
      v_pipe[0] <= in_vcnt;
      h_pipe[0] <= in_hcnt;
      for (int i = 1; i < LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        h_pipe[i] <= h_pipe[i-1];
      end
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      armed     <= 1'b0;
      act_mode  <= 2'd0;
      lb_ptr    <= '0;
      for (int i = 0; i < LAT; i++) a_pipe[i] <= 1'b0;
      out_patch <= '0;
      out_vcnt  <= '0;
      out_hcnt  <= '0;
      out_valid <= 1'b0;
    end else if (enable) begin
      armed     <= armed_next;
      a_pipe[0] <= armed_next;
      for (int i = 1; i < LAT; i++) a_pipe[i] <= a_pipe[i-1];
      if (lb_ptr == PTR_W'(LB_DEPTH - 1)) lb_ptr <= '0;
      else                                lb_ptr <= lb_ptr + 1'b1;
      if (ctr_v == '0 && ctr_h == '0) act_mode <= pad_mode;
      out_valid <= patch_valid;
      out_patch <= patch_valid ? patch : '0;
      out_vcnt  <= ctr_v;
      out_hcnt  <= ctr_h;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_patch_mc.sv
module tb_stream_patch_mc;

  localparam int BW  = 8;
  localparam int CHN = 2;
  localparam int IH  = 6;
  localparam int IW  = 8;
  localparam int FH  = 8;
  localparam int FW  = 10;
  localparam int PH  = 3;
  localparam int PW  = 3;
  localparam int VW  = $clog2(FH);
  localparam int HW  = $clog2(FW);
  localparam int PB  = BW * CHN * PH * PW;
  localparam int EW  = VW + HW + PB;

  // ---------------- clock / reset / signals ----------------
  logic              clock = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [1:0]        pad_mode = 2'd0;
  logic [BW*CHN-1:0] in_pixel = '0;
  logic [VW-1:0]     in_vcnt = '0;
  logic [HW-1:0]     in_hcnt = '0;
  logic [0:PB-1]     out_patch;
  logic [VW-1:0]     out_vcnt;
  logic [HW-1:0]     out_hcnt;
  logic              out_valid;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int zero_cycle = 0;
  bit lat_chk = 1'b0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  logic [7:0] hand_ch0 [5][9];
  logic [8:0] hand_pad [5];
  int         hand_mode [5];
  int         hand_v [5];
  int         hand_h [5];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  stream_patch_mc #(
    .BIT_WIDTH(BW), .CHANNELS(CHN), .IMAGE_HEIGHT(IH), .IMAGE_WIDTH(IW),
    .FRAME_HEIGHT(FH), .FRAME_WIDTH(FW), .PATCH_HEIGHT(PH), .PATCH_WIDTH(PW)
  ) dut (
    .clock(clock), .rst(rst), .enable(enable), .pad_mode(pad_mode),
    .in_pixel(in_pixel), .in_vcnt(in_vcnt), .in_hcnt(in_hcnt),
    .out_patch(out_patch), .out_vcnt(out_vcnt), .out_hcnt(out_hcnt),
    .out_valid(out_valid)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] pix(input int v, input int h);
    logic [7:0] b;
    b = 8'(v * 16 + h);
    return {~b, b};
  endfunction

  function automatic int map_idx(input int p, input int n, input int mode);
    if (p >= 0 && p < n) return p;
    case (mode)
      1:       return (p < 0) ? 0 : n - 1;
      2:       return (p < 0) ? -p : 2 * n - 2 - p;
      default: return -1;
    endcase
  endfunction

  // Reference patch built straight from image coordinates.
  function automatic logic [0:PB-1] model(input int mode, input int cv, input int chz);
    logic [0:PB-1] p;
    logic [7:0] b;
    int r;
    int c;
    int e;
    p = '0;
    for (int v = 0; v < PH; v++) begin
      for (int h = 0; h < PW; h++) begin
        r = map_idx(cv + v - 1, IH, mode);
        c = map_idx(chz + h - 1, IW, mode);
        e = v * PW + h;
        if (r >= 0 && c >= 0) begin
          b = 8'(r * 16 + c);
          p[(2 * e) * 8 +: 8]     = b;
          p[(2 * e + 1) * 8 +: 8] = ~b;
        end
      end
    end
    return p;
  endfunction

  // Hand-computed patches take precedence over the model where listed.
  function automatic logic [0:PB-1] exp_patch(input int mode, input int v, input int h);
    logic [0:PB-1] p;
    logic [7:0] b;
    p = model(mode, v, h);
    for (int k = 0; k < 5; k++) begin
      if (hand_mode[k] == mode && hand_v[k] == v && hand_h[k] == h) begin
        p = '0;
        for (int e = 0; e < 9; e++) begin
          b = hand_ch0[k][e];
          p[(2 * e) * 8 +: 8]     = hand_pad[k][e] ? 8'h00 : b;
          p[(2 * e + 1) * 8 +: 8] = hand_pad[k][e] ? 8'h00 : ~b;
        end
      end
    end
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input int v, input int h, input bit rnd);
    bit go;
    go = 1'b0;
    while (!go) begin
      go       = rnd ? ($urandom_range(0, 9) >= 4) : 1'b1;
      enable   = go;
      in_vcnt  = VW'(v);
      in_hcnt  = HW'(h);
      in_pixel = pix(v, h);
      if (go && v == 0 && h == 0) begin
        zero_cycle = cyc;
        lat_chk    = !rnd;
      end
      @(posedge clock); #1;
    end
  endtask

  // kind: 0 plain, 1 five-cycle stall at ctr (3,7), 2 pad switch at ctr (2,4),
  // 3 reset pulse at ctr (3,3)
  task automatic run_frame(input int mode, input bit rnd, input int kind);
    logic [0:PB-1] hold;
    pad_mode = 2'(mode);
    for (int v = 0; v < IH; v++) begin
      for (int h = 0; h < IW; h++) begin
        if (!(kind == 3 && v * FW + h >= 33))
          exp_q.push_back({VW'(v), HW'(h), exp_patch(mode, v, h)});
      end
    end
    for (int v = 0; v < FH; v++) begin
      for (int h = 0; h < FW; h++) begin
        if (kind == 2 && v == 3 && h == 6) pad_mode = 2'd2;
        if (kind == 1 && v == 4 && h == 9) begin
          hold = exp_patch(1, 3, 6);
          for (int i = 0; i < 5; i++) begin
            enable = 1'b0;
            @(posedge clock); #1;
            check("stall_valid", 192'(out_valid), 192'(0));
            check("stall_patch", 192'(out_patch), 192'(hold));
            check("stall_coord", 192'({out_vcnt, out_hcnt}), 192'({3'd3, 4'd6}));
          end
        end
        if (kind == 3 && v == 4 && h == 5) begin
          rst    = 1'b1;
          enable = 1'b0;
          @(posedge clock); #1;
          rst = 1'b0;
          check("rst_valid", 192'(out_valid), 192'(0));
          check("rst_patch", 192'(out_patch), 192'(0));
        end
        send(v, h, rnd);
      end
    end
    check("frame_drained", 192'(exp_q.size()), 192'(0));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: got coord %0d,%0d expected no output", out_vcnt, out_hcnt);
      end else begin
        mon_e = exp_q.pop_front();
        check("coord", 192'({out_vcnt, out_hcnt}), 192'(mon_e[EW-1 -: VW+HW]));
        check("patch", 192'(out_patch), 192'(mon_e[PB-1:0]));
        if (lat_chk && out_vcnt == '0 && out_hcnt == '0)
          check("latency", 192'(cyc - zero_cycle), 192'(13));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    hand_ch0[0] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h10, 8'h10, 8'h11};
    hand_pad[0] = 9'h000; hand_mode[0] = 1; hand_v[0] = 0; hand_h[0] = 0;
    hand_ch0[1] = '{8'h11, 8'h10, 8'h11, 8'h01, 8'h00, 8'h01, 8'h11, 8'h10, 8'h11};
    hand_pad[1] = 9'h000; hand_mode[1] = 2; hand_v[1] = 0; hand_h[1] = 0;
    hand_ch0[2] = '{8'h46, 8'h47, 8'h46, 8'h56, 8'h57, 8'h56, 8'h46, 8'h47, 8'h46};
    hand_pad[2] = 9'h000; hand_mode[2] = 2; hand_v[2] = 5; hand_h[2] = 7;
    hand_ch0[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h10, 8'h11};
    hand_pad[3] = 9'h04F; hand_mode[3] = 0; hand_v[3] = 0; hand_h[3] = 0;
    hand_ch0[4] = '{8'h12, 8'h13, 8'h14, 8'h22, 8'h23, 8'h24, 8'h32, 8'h33, 8'h34};
    hand_pad[4] = 9'h000; hand_mode[4] = 0; hand_v[4] = 2; hand_h[4] = 3;

    rst    = 1'b1;
    enable = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
    check("reset_valid", 192'(out_valid), 192'(0));
    check("reset_patch", 192'(out_patch), 192'(0));
    check("reset_vcnt", 192'(out_vcnt), 192'(0));
    check("reset_hcnt", 192'(out_hcnt), 192'(0));

    run_frame(1, 1'b0, 0);  // replicate
    run_frame(2, 1'b0, 0);  // mirror
    run_frame(0, 1'b0, 0);  // zero
    run_frame(1, 1'b1, 1);  // replicate, random enable with long stall
    run_frame(1, 1'b0, 2);  // replicate, mode switched mid-frame
    run_frame(2, 1'b0, 0);  // switched mode takes effect here
    run_frame(1, 1'b0, 3);  // reset pulse mid-frame
    run_frame(1, 1'b0, 0);  // recovery after reset

    enable = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("final_drained", 192'(exp_q.size()), 192'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    n_checks++;
    $display("FAIL timeout: got no completion expected completion by 100000");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
